// File: rtl/input_conditioner.sv
// Board input front end for the stopwatch core: two-flop synchronisers, per-input
// debouncers, pause toggle state and registered one-hot mode / clear outputs.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_reset,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic regular_mode,
  output logic adjust_seconds_mode,
  output logic adjust_minutes_mode,
  output logic pause_mode,
  output logic clear_pulse
);

  localparam int unsigned N_IN    = 4;
  localparam int unsigned I_PAUSE = 0;
  localparam int unsigned I_RESET = 1;
  localparam int unsigned I_ADJ   = 2;
  localparam int unsigned I_SEL   = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Mode register encoding: bit0 regular, bit1 seconds, bit2 minutes, bit3 pause
  localparam logic [3:0] MODE_REG   = 4'b0001;
  localparam logic [3:0] MODE_SEC   = 4'b0010;
  localparam logic [3:0] MODE_MIN   = 4'b0100;
  localparam logic [3:0] MODE_PAUSE = 4'b1000;

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  s1_q, s2_q;
  logic [N_IN-1:0]  db_q, db_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [1:0]       db_hist_q;
  logic             rise_pause, rise_reset;
  logic             paused_q, paused_d;
  logic             clear_q;
  logic [3:0]       mode_q, mode_d;

  assign raw = {sw_sel, sw_adj, btn_reset, btn_pause};

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i]  = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign rise_pause = db_q[I_PAUSE] & ~db_hist_q[0];
  assign rise_reset = db_q[I_RESET] & ~db_hist_q[1];

  // Mode uses the next paused value so a pause press shows on the same edge as the toggle
  always_comb begin
    paused_d = paused_q;
    if (rise_reset)                     paused_d = 1'b0;
    else if (rise_pause && !db_q[I_ADJ]) paused_d = ~paused_q;

    if (db_q[I_ADJ] && db_q[I_SEL]) mode_d = MODE_SEC;
    else if (db_q[I_ADJ])           mode_d = MODE_MIN;
    else if (paused_d)              mode_d = MODE_PAUSE;
    else                            mode_d = MODE_REG;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_hist_q <= '0;
      paused_q  <= 1'b0;
      clear_q   <= 1'b0;
      mode_q    <= MODE_REG;
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_hist_q <= {db_q[I_RESET], db_q[I_PAUSE]};
      paused_q  <= paused_d;
      clear_q   <= rise_reset;
      mode_q    <= mode_d;
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign regular_mode        = mode_q[0];
  assign adjust_seconds_mode = mode_q[1];
  assign adjust_minutes_mode = mode_q[2];
  assign pause_mode          = mode_q[3];
  assign clear_pulse         = clear_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random input
// sequences, all compared every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_pause = 1'b0, btn_reset = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic regular_mode, adjust_seconds_mode, adjust_minutes_mode, pause_mode, clear_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .btn_pause           (btn_pause),
    .btn_reset           (btn_reset),
    .sw_adj              (sw_adj),
    .sw_sel              (sw_sel),
    .regular_mode        (regular_mode),
    .adjust_seconds_mode (adjust_seconds_mode),
    .adjust_minutes_mode (adjust_minutes_mode),
    .pause_mode          (pause_mode),
    .clear_pulse         (clear_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an input is accepted once its synchronised value has been seen
  // unchanged for DB consecutive edges while differing from the accepted level.
  bit [3:0] m_s1, m_s2, m_db, m_last;
  int       m_run [4];
  bit       m_rose_p, m_rose_r, m_paused, m_clear;
  bit       m_reg, m_sec, m_min, m_pau;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_last = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_rose_p = 0; m_rose_r = 0; m_paused = 0; m_clear = 0;
      m_reg = 1; m_sec = 0; m_min = 0; m_pau = 0;
    end else begin
      m_clear = m_rose_r;
      if (m_rose_r) m_paused = 0;
      else if (m_rose_p && !m_db[2]) m_paused = !m_paused;
      m_reg = 0; m_sec = 0; m_min = 0; m_pau = 0;
      if (m_db[2] && m_db[3]) m_sec = 1;
      else if (m_db[2])       m_min = 1;
      else if (m_paused)      m_pau = 1;
      else                    m_reg = 1;
      m_rose_p = 0; m_rose_r = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_last[i]) m_run[i]++;
        else                      m_run[i] = 1;
        m_last[i] = m_s2[i];
        if (m_s2[i] != m_db[i] && m_run[i] >= DB) begin
          m_db[i] = m_s2[i];
          if (m_s2[i] && i == 0) m_rose_p = 1;
          if (m_s2[i] && i == 1) m_rose_r = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = {sw_sel, sw_adj, btn_reset, btn_pause};
    end
  end

  always @(negedge clk) begin
    check("outs", {regular_mode, adjust_seconds_mode, adjust_minutes_mode, pause_mode, clear_pulse},
          {m_reg, m_sec, m_min, m_pau, m_clear});
    check("onehot", 8'($onehot({regular_mode, adjust_seconds_mode, adjust_minutes_mode, pause_mode})), 8'd1);
  end

  task automatic set_in(input logic bp, input logic br, input logic adj, input logic sel);
    @(negedge clk); #2;
    btn_pause = bp; btn_reset = br; sw_adj = adj; sw_sel = sel;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses;

  initial begin
    repeat (3) @(posedge clk);
    #1 check("rst_vals", {regular_mode, adjust_seconds_mode, adjust_minutes_mode, pause_mode, clear_pulse}, 8'b10000);
    @(negedge clk); #2 rst = 1'b1;
    wait_cyc(10);
    check("after_rst", {regular_mode, pause_mode, clear_pulse}, 8'b100);

    // Clean press: visible exactly on edge DB+3 after first sampling
    set_in(1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) check("press_e6", pause_mode, 1'b0);
      if (k == 7) check("press_e7", {pause_mode, regular_mode}, 8'b10);
    end
    wait_cyc(13);
    set_in(0, 0, 0, 0); wait_cyc(12);
    set_in(1, 0, 0, 0); wait_cyc(12);
    set_in(0, 0, 0, 0); wait_cyc(12);
    check("unpause", regular_mode, 1'b1);

    // Bounce shorter than the debounce window
    for (int k = 0; k < 6; k++) begin
      set_in(1, 0, 0, 0); wait_cyc(1);
      set_in(0, 0, 0, 0); wait_cyc(1);
    end
    wait_cyc(12);
    check("bounce_low", pause_mode, 1'b0);
    for (int k = 0; k < 6; k++) begin
      set_in(1, 0, 0, 0); wait_cyc(1);
      set_in(0, 0, 0, 0); wait_cyc(1);
    end
    set_in(1, 0, 0, 0); wait_cyc(12);
    check("bounce_high", pause_mode, 1'b1);
    set_in(0, 0, 0, 0); wait_cyc(12);

    // Adjust priority over pause, pause presses ignored while adjusting
    set_in(0, 0, 1, 1); wait_cyc(10);
    check("adj_sec", adjust_seconds_mode, 1'b1);
    set_in(0, 0, 1, 0); wait_cyc(10);
    check("adj_min", adjust_minutes_mode, 1'b1);
    set_in(1, 0, 1, 0); wait_cyc(10);
    set_in(0, 0, 1, 0); wait_cyc(10);
    check("adj_ignore", adjust_minutes_mode, 1'b1);
    set_in(0, 0, 0, 0); wait_cyc(10);
    check("adj_exit", pause_mode, 1'b1);

    // Reset button: one pulse per press, clears pause
    for (int p = 0; p < 2; p++) begin
      pulses = 0;
      set_in(0, 1, 0, 0);
      repeat (30) begin
        @(negedge clk);
        if (clear_pulse) pulses++;
      end
      check("clr_count", 8'(pulses), 8'd1);
      check("clr_mode", regular_mode, 1'b1);
      set_in(0, 0, 0, 0); wait_cyc(10);
    end

    // Async reset in the middle of a debounce count
    set_in(1, 0, 0, 0); wait_cyc(3);
    @(posedge clk); #3 rst = 1'b0;
    #1 check("async_rst", {regular_mode, adjust_seconds_mode, adjust_minutes_mode, pause_mode, clear_pulse}, 8'b10000);
    @(negedge clk); #2 rst = 1'b1;
    wait_cyc(5);
    check("post_rst_hold", pause_mode, 1'b0);
    wait_cyc(5);
    check("post_rst_toggle", pause_mode, 1'b1);
    set_in(0, 0, 0, 0); wait_cyc(10);

    // Random input sequences
    for (int k = 0; k < 300; k++) begin
      set_in(1'($urandom), ($urandom_range(7) == 0), 1'($urandom), 1'($urandom));
      wait_cyc($urandom_range(8, 1));
    end
    wait_cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front end for the stopwatch core.
- Synchronises and debounces the raw board pause button, reset button and two mode switches.
- Keeps the pause toggle state.
- Drives the core's one-hot mode inputs (regular / adjust-seconds / adjust-minutes / pause) plus a one-cycle clear request wired to the core's reset input.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised input must hold a new level before it is accepted (5 ms at 100 MHz; benches use 4).
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- btn_pause  input  1  raw pause pushbutton, asynchronous, bouncy
- btn_reset  input  1  raw reset pushbutton, asynchronous, bouncy
- sw_adj  input  1  raw ADJ switch; 1 = adjust mode
- sw_sel  input  1  raw SEL switch; 1 = adjust seconds, 0 = adjust minutes
- regular_mode  output  1  core counts normally
- adjust_seconds_mode  output  1  core adjusts seconds
- adjust_minutes_mode  output  1  core adjusts minutes
- pause_mode  output  1  core frozen
- clear_pulse  output  1  one-cycle request to zero the core

Behaviour:
- Reset (rst=0, async):
  - all synchroniser flops, debounced levels, counters, edge-history flops and the paused flag go to 0;
  - regular_mode=1; adjust_seconds_mode, adjust_minutes_mode, pause_mode, clear_pulse all 0.
- Reset release:
  - takes effect on the first clk rising edge with rst=1;
  - rst asserted mid-operation discards any in-progress debounce count and pause state immediately.
- Synchroniser: each raw input passes through two flops (s1, s2).
- Debouncer (one per input, identical):
  - if s2 == db, cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1, db <= s2 and cnt <= 0;
  - else cnt <= cnt+1.
  - A level at s2 shorter than DEBOUNCE_CYCLES consecutive cycles never reaches db.
  - Any return to the old level restarts the count.
- Latency, counting the edge that first samples the raw change as edge 1:
  - s2 changes at edge 2;
  - db changes at edge DEBOUNCE_CYCLES+2;
  - registered outputs change at edge DEBOUNCE_CYCLES+3.
- Edge detect: rise_x = db_x & ~db_x_d, where db_x_d is db_x delayed one cycle.
- Pause flag:
  - a rise on btn_pause toggles paused, but only while the debounced sw_adj is 0;
  - rises during adjust mode are ignored and paused keeps its value.
- Reset button:
  - a rise on btn_reset registers clear_pulse=1 for exactly one cycle and forces paused <= 0 in the same cycle;
  - a simultaneous pause rise in that cycle loses (paused ends 0).
  - Holding btn_reset gives a single pulse; no repeat until release and re-press.
- Mode select, registered, priority order:
  1. db_adj=1 & db_sel=1 -> adjust_seconds_mode
  2. db_adj=1 & db_sel=0 -> adjust_minutes_mode
  3. paused=1 -> pause_mode
  4. otherwise -> regular_mode
- Mode outputs are one-hot at all times, including reset; never zero-hot or multi-hot.
- Leaving adjust mode restores pause_mode if paused was 1 before entry.
- Toggling SEL while in adjust switches between seconds and minutes after the debounce latency.
- No combinational path from any raw input to any output.

Test Plan (DEBOUNCE_CYCLES=4, 10 ns clk):
- Reset: rst=0 for 3 cycles, then release with all raw inputs 0 -> regular_mode=1, others 0, clear_pulse=0 throughout and after.
- Clean press: btn_pause raised and held 20 cycles -> pause_mode=1, regular_mode=0 exactly at edge 7 after first sampling. Release, then press again -> regular_mode=1.
- Bounce: btn_pause toggles 1/0 every 2 cycles for 12 cycles, then held 0 -> no output change, pause_mode stays 0. Same toggling then held 1 -> single pause toggle.
- Adjust priority: paused=1, then sw_adj=1 with sw_sel=1 -> adjust_seconds_mode=1. sw_sel->0 -> adjust_minutes_mode=1. btn_pause press during adjust -> ignored. sw_adj->0 -> pause_mode=1.
- Reset button: paused=1, btn_reset held 30 cycles -> exactly one clear_pulse cycle, then regular_mode=1. A second press gives a second single pulse.
- Async reset mid-debounce: btn_pause high for 3 stable cycles, then rst=0 for 1 cycle mid-clock -> outputs return to reset values immediately, no pause toggle after release until 4 fresh stable cycles.
